// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and IF/ID register with valid/ready handshake and branch redirect.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count/flush_count outputs.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        busy,
    output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_END = 2'd2;
    localparam logic [31:0] LIMIT = 32'(IMEM_WORDS) << 2;
    logic [1:0] state;
    logic [31:0] pc, pc_plus4, tgt;
    logic redirect, load;
    assign imem_addr = pc;
    assign busy      = state == S_RUN;
    assign pc_plus4  = pc + 32'd4;
    assign tgt       = branch_target & ~32'h3;
    assign redirect  = branch_taken & (state != S_IDLE);
    assign load      = (state == S_RUN) & (!out_valid | out_ready) & !branch_taken;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_pc       <= '0;
            out_pc_plus4 <= '0;
            misalign_err <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start) state <= S_RUN;
        end else if (redirect) begin
            pc        <= tgt;
            out_valid <= 1'b0;
            state     <= tgt < LIMIT ? S_RUN : S_END;
            if (|branch_target[1:0]) misalign_err <= 1'b1;
        end else if (load) begin
            out_instr    <= imem_instr;
            out_pc       <= pc;
            out_pc_plus4 <= pc_plus4;
            out_valid    <= 1'b1;
            pc           <= pc_plus4;
            if (pc_plus4 >= LIMIT) state <= S_END;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (load && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
            if (redirect && out_valid && flush_count != '1) flush_count <= flush_count + 16'd1;
        end
    end
`endif
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the combinational instruction_memory: owns the program counter, drives the memory address, captures the returned word and presents it to the decode stage through an IF/ID output register with valid/ready handshake.
- Accepts branch redirects from the execute stage (beq resolution) and flushes the wrong-path word.

Parameters:
- RESET_PC, 32'h00000000, byte address loaded into PC on reset.
- IMEM_WORDS, 64, instruction memory depth in words; fetch range is [0, IMEM_WORDS*4).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; leaves IDLE and begins fetching.
- imem_addr  output  32  byte address to instruction_memory; equals PC register.
- imem_instr  input  32  word returned combinationally by instruction_memory for imem_addr.
- out_valid  output  1  IF/ID register holds a valid instruction.
- out_ready  input  1  decode accepts out_* this cycle.
- out_instr  output  32  fetched instruction.
- out_pc  output  32  address of out_instr.
- out_pc_plus4  output  32  out_pc + 4, mod 2^32.
- branch_taken  input  1  redirect request from execute.
- branch_target  input  32  redirect byte address.
- busy  output  1  state is RUN.
- misalign_err  output  1  sticky; a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async, immediate): state=IDLE, PC=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, misalign_err=0. Reset asserted mid-operation discards everything in flight.
- imem_addr = PC, combinational from register; no gating.
- load = (state==RUN) & (!out_valid | out_ready) & !branch_taken.
- On load: out_instr<=imem_instr, out_pc<=PC, out_pc_plus4<=PC+4, out_valid<=1, PC<=PC+4. One word per cycle; latency from PC change to out_valid is 1 cycle.
- Handshake: out_valid & !out_ready holds all out_* and PC stable (stall). out_valid & out_ready with no new load clears out_valid.
- Redirect has top priority over load and stall, in any state except IDLE: PC<=branch_target & ~32'h3; out_valid<=0 (flush, even if out_ready=1 that cycle); state<=RUN if aligned target < IMEM_WORDS*4, else END. If branch_target[1:0]!=0, misalign_err<=1 (cleared only by reset).
- States:
  - IDLE: no loads; start -> RUN. branch_taken ignored.
  - RUN: loads as above. When a load's PC+4 >= IMEM_WORDS*4 -> END (last word still delivered).
  - END: no loads; out_valid drains normally; only redirect or reset leaves.
- start outside IDLE is ignored. start and branch_taken together in IDLE: start wins, PC unchanged.
- PC arithmetic is 32-bit unsigned with wrap; the range check prevents fetch beyond memory.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds output fetch_count (32 bits) and output flush_count (16 bits), both reset to 0. fetch_count +1 on every load. flush_count +1 on every redirect that discards out_valid=1. Both saturate at all-ones.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, start, out_ready=1, memory holds addi $s0,$0,4 = 32'h20100004 at 0x0 -> cycle after start: out_valid=1, out_pc=0x0, out_instr=32'h20100004, out_pc_plus4=0x4; then one word per cycle at 0x4, 0x8, 0xC.
- Hold out_ready=0 for 3 cycles with out_pc=0x8 -> out_* and imem_addr stay 0x8/0xC. Release -> 0xC delivered next cycle, no word skipped or duplicated.
- branch_taken=1 with branch_target=0x34 while out_pc=0x10 is valid -> next cycle out_valid=0, imem_addr=0x34; following cycle out_pc=0x34.
- IMEM_WORDS=14, run to the end -> word at 0x34 delivered, state END, busy=0, out_valid drops after accept. Redirect to 0x0 -> RUN resumes.
- Redirect to 0x0000001E -> imem_addr=0x1C, misalign_err=1 and stays 1. Redirect to 0x40 with IMEM_WORDS=14 -> END, no loads.
- Assert reset mid-stream with out_valid=1 -> all outputs zero and PC=RESET_PC without waiting for a clock edge. With FETCH_PERF_CNT_EN: after 5 loads and one flush of a valid word, fetch_count=5 and flush_count=1.
